// File: rtl/alu_mc_if.sv
// Request/result handshake bundle for the multi-cycle ALU.
// The requester drives operands and out_ready; the ALU drives in_ready and results.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, ctrl, in1, in2, out_ready,
        input  in_ready, out_valid, out, zero, overflow
    );

    modport slave (
        input  in_valid, ctrl, in1, in2, out_ready,
        output in_ready, out_valid, out, zero, overflow
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/shift ops plus iterative
// unsigned MULTU/DIVU into HI/LO, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mc_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   out_reg, hi_reg, lo_reg, opb_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic               div_reg, zero_reg, ovf_reg, valid_reg, ready_reg;

    logic [WIDTH-1:0]   alu_res, sum, diff;
    logic               alu_ovf;
    logic [WIDTH:0]     mul_sum, div_part;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        sum     = bus.in1 + bus.in2;
        diff    = bus.in1 - bus.in2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.ctrl)
            OP_AND:  alu_res = bus.in1 & bus.in2;
            OP_OR:   alu_res = bus.in1 | bus.in2;
            OP_NOR:  alu_res = ~(bus.in1 | bus.in2);
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (diff[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.in1) < $signed(bus.in2)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.in1 < bus.in2};
            OP_SLL:  alu_res = bus.in1 << bus.in2[SW-1:0];
            OP_SRL:  alu_res = bus.in1 >> bus.in2[SW-1:0];
            OP_SRA:  alu_res = $unsigned($signed(bus.in1) >>> bus.in2[SW-1:0]);
            OP_MFHI: alu_res = hi_reg;
            OP_MFLO: alu_res = lo_reg;
            default: alu_res = '0;
        endcase
    end

    // acc_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opb_reg};
        div_part = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        if (div_reg) begin
            if (div_part >= {1'b0, opb_reg}) begin
                acc_next = {div_part[WIDTH-1:0] - opb_reg, acc_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc_reg[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc_reg[0]) begin
            acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc_reg[2*WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            out_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            opb_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            div_reg   <= 1'b0;
            zero_reg  <= 1'b1;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        ready_reg <= 1'b0;
                        if (bus.ctrl == OP_MULTU || bus.ctrl == OP_DIVU) begin
                            acc_reg   <= {{WIDTH{1'b0}}, bus.in1};
                            opb_reg   <= bus.in2;
                            div_reg   <= (bus.ctrl == OP_DIVU);
                            cnt_reg   <= CW'(WIDTH);
                            state_reg <= BUSY;
                        end else begin
                            out_reg   <= alu_res;
                            zero_reg  <= (alu_res == '0);
                            ovf_reg   <= alu_ovf;
                            valid_reg <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        hi_reg    <= acc_next[2*WIDTH-1:WIDTH];
                        lo_reg    <= acc_next[WIDTH-1:0];
                        out_reg   <= acc_next[WIDTH-1:0];
                        zero_reg  <= (acc_next[WIDTH-1:0] == '0);
                        ovf_reg   <= 1'b0;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_reg;
    assign bus.out_valid = valid_reg;
    assign bus.out       = out_reg;
    assign bus.zero      = zero_reg;
    assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc against an arithmetic reference model.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference: plain integer arithmetic, updates the model HI/LO for long ops
    task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov, output int lat);
        longint s;
        logic [63:0] p;
        r = '0; ov = 1'b0; lat = 1;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  r = (a < b) ? 32'd1 : 32'd0;
            4'd3:  r = a << (b % 32);
            4'd4:  r = a >> (b % 32);
            4'd5:  r = $unsigned($signed(a) >>> (b % 32));
            4'd9: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33;
            end
            4'd10: begin
                if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
                else begin m_lo = a / b; m_hi = a % b; end
                r = m_lo; lat = 33;
            end
            4'd13: r = m_hi;
            4'd14: r = m_lo;
            default: r = '0;
        endcase
    endtask

    // Drive one request from IDLE, wait (bounded) for the result, then hand it off
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic ov,
                         output int lat, output logic pv, output logic pr);
        bus.ctrl = c; bus.in1 = a; bus.in2 = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in1 = $urandom; bus.in2 = $urandom; bus.ctrl = 4'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        r = bus.out; z = bus.zero; ov = bus.overflow;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        pv = bus.out_valid; pr = bus.in_ready;
    endtask

    task automatic test_reset();
        total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b exp=1", bus.zero); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.in_ready); end
        $display("reset: out=%h zero=%b ovf=%b valid=%b ready=%b", bus.out, bus.zero, bus.overflow, bus.out_valid, bus.in_ready);
    endtask

    task automatic test_addsub();
        logic [31:0] r; logic z, ov, pv, pr; int lat;
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, r, z, ov, lat, pv, pr);
        $display("ADD 7fffffff+1: out=%h zero=%b ovf=%b lat=%0d", r, z, ov, lat);
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL add_out got=%h exp=80000000", r); end
        total++; if (ov !== 1'b1 || z !== 1'b0) begin bad++; $display("FAIL add_flags got=%b%b exp=10", ov, z); end
        total++; if (lat != 1) begin bad++; $display("FAIL add_lat got=%0d exp=1", lat); end
        total++; if (pv !== 1'b0 || pr !== 1'b1) begin bad++; $display("FAIL add_return got=%b%b exp=01", pv, pr); end
        issue(4'b0110, 32'd5, 32'd5, r, z, ov, lat, pv, pr);
        $display("SUB 5-5: out=%h zero=%b ovf=%b lat=%0d", r, z, ov, lat);
        total++; if (r !== 32'd0 || z !== 1'b1 || ov !== 1'b0) begin bad++; $display("FAIL sub_zero got=%h/%b/%b exp=0/1/0", r, z, ov); end
    endtask

    task automatic test_mul();
        logic [31:0] r; logic z, ov, pv, pr; int lat;
        issue(4'b1001, 32'hFFFF_FFFF, 32'h2, r, z, ov, lat, pv, pr);
        $display("MULTU ffffffff*2: out=%h lat=%0d", r, lat);
        total++; if (lat != 33) begin bad++; $display("FAIL mul_lat got=%0d exp=33", lat); end
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_lo got=%h exp=fffffffe", r); end
        issue(4'b1101, 32'h0, 32'h0, r, z, ov, lat, pv, pr);
        $display("MFHI: out=%h", r);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL mul_hi got=%h exp=1", r); end
        m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
    endtask

    task automatic test_div();
        logic [31:0] r; logic z, ov, pv, pr; int lat;
        issue(4'b1010, 32'd100, 32'd7, r, z, ov, lat, pv, pr);
        $display("DIVU 100/7: lo=%0d lat=%0d", r, lat);
        total++; if (r !== 32'd14) begin bad++; $display("FAIL div_q got=%0d exp=14", r); end
        issue(4'b1101, 32'h0, 32'h0, r, z, ov, lat, pv, pr);
        $display("MFHI: out=%0d", r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL div_r got=%0d exp=2", r); end
        issue(4'b1010, 32'd5, 32'd0, r, z, ov, lat, pv, pr);
        $display("DIVU 5/0: lo=%h lat=%0d", r, lat);
        total++; if (r !== 32'hFFFF_FFFF || lat != 33) begin bad++; $display("FAIL div0_lo got=%h/%0d exp=ffffffff/33", r, lat); end
        issue(4'b1101, 32'h0, 32'h0, r, z, ov, lat, pv, pr);
        $display("MFHI: out=%0d", r);
        total++; if (r !== 32'd5) begin bad++; $display("FAIL div0_hi got=%0d exp=5", r); end
        m_hi = 32'd5; m_lo = 32'hFFFF_FFFF;
    endtask

    task automatic test_cmp_shift();
        logic [3:0]  cs [5] = '{4'b0111, 4'b1000, 4'b0101, 4'b0100, 4'b1111};
        logic [31:0] as [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
        logic [31:0] bs [5] = '{32'h1, 32'h1, 32'h24, 32'h24, 32'h9};
        logic [31:0] es [5] = '{32'h1, 32'h0, 32'hF800_0000, 32'h0800_0000, 32'h0};
        logic [31:0] r; logic z, ov, pv, pr; int lat;
        for (int i = 0; i < 5; i++) begin
            issue(cs[i], as[i], bs[i], r, z, ov, lat, pv, pr);
            $display("op=%b a=%h b=%h: out=%h zero=%b", cs[i], as[i], bs[i], r, z);
            total++;
            if (r !== es[i] || z !== (es[i] == 0)) begin
                bad++; $display("FAIL cmpshift_%0d got=%h/%b exp=%h", i, r, z, es[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int lat;
        bus.ctrl = 4'b0010; bus.in1 = 32'd40; bus.in2 = 32'd2; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        held = bus.out;
        total++; if (held !== 32'd42) begin bad++; $display("FAIL bp_out got=%0d exp=42", held); end
        bus.ctrl = 4'b0000; bus.in1 = 32'hF0F0_1234; bus.in2 = 32'h0FF0_FFFF; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.out !== 32'd42 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold_%0d got=%h/%b/%b exp=2a/0/1", i, bus.out, bus.in_ready, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("backpressure release: valid=%b ready=%b", bus.out_valid, bus.in_ready);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b%b exp=01", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        $display("held AND accepted: valid=%b out=%h", bus.out_valid, bus.out);
        total++; if (bus.out_valid !== 1'b1 || bus.out !== (32'hF0F0_1234 & 32'h0FF0_FFFF)) begin
            bad++; $display("FAIL bp_next got=%b/%h exp=1/00f01234", bus.out_valid, bus.out);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] r; logic z, ov, pv, pr; int lat;
        bus.ctrl = 4'b1001; bus.in1 = 32'hDEAD_BEEF; bus.in2 = 32'h1234_5678; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        $display("reset mid-MULTU: valid=%b ready=%b", bus.out_valid, bus.in_ready);
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b%b exp=01", bus.out_valid, bus.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        m_hi = '0; m_lo = '0;
        issue(4'b1101, 32'h0, 32'h0, r, z, ov, lat, pv, pr);
        $display("MFHI after reset: out=%h", r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL midrst_hi got=%h exp=0", r); end
        issue(4'b1110, 32'h0, 32'h0, r, z, ov, lat, pv, pr);
        $display("MFLO after reset: out=%h", r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", r); end
    endtask

    task automatic test_random();
        logic [31:0] r, er, a, b; logic z, ov, eov, pv, pr; logic [3:0] c; int lat, elat;
        for (int i = 0; i < 60; i++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            model(c, a, b, er, eov, elat);
            issue(c, a, b, r, z, ov, lat, pv, pr);
            $display("rand %0d op=%b a=%h b=%h out=%h ovf=%b lat=%0d", i, c, a, b, r, ov, lat);
            total++;
            if (r !== er || z !== (er == 0) || ov !== eov || lat != elat) begin
                bad++; $display("FAIL rand_%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", i, r, z, ov, lat, er, er == 0, eov, elat);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.ctrl = '0; bus.in1 = '0; bus.in2 = '0;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_addsub();
        test_mul();
        test_div();
        test_cmp_shift();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes logic, arithmetic, compare and shift ops with one-cycle latency.
- Adds iterative unsigned multiply/divide into internal HI/LO registers, plus MFHI/MFLO reads.
- Sits between the ID/EX operand registers and writeback. Uses a valid/ready handshake on both sides so the core can stall on long ops.

Parameters:
- WIDTH, 32: operand, result, HI and LO width. Must be ≥ 4 and a power of 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- ctrl  in  4  operation select
- in1  in  WIDTH  operand A (dividend/shifted value)
- in2  in  WIDTH  operand B (divisor/shift amount)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  WIDTH  registered result
- zero  out  1  (out == 0), registered with out
- overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out, hi, lo = 0; zero=1; overflow=0; out_valid=0; counter=0. Applies immediately, including mid-BUSY; a partial mul/div is discarded.
- ctrl encoding:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100 (same as current ALU).
  - SLT 0111 (signed), SLTU 1000.
  - SLL 0011, SRL 0100, SRA 0101.
  - MULTU 1001, DIVU 1010, MFHI 1101, MFLO 1110.
  - Any other code yields out=0.
- Shifts: in1 shifted by in2[$clog2(WIDTH)-1:0]; upper bits of in2 ignored.
- SLT/SLTU: out = 1 or 0, zero-extended to WIDTH.
- ADD/SUB: result wraps modulo 2^WIDTH. overflow=1 on signed overflow.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1; acceptance = in_valid & in_ready at a rising edge.
  - Single-cycle op: result, zero and overflow registered at the accept edge; go to DONE. out_valid is high the cycle after acceptance.
  - MULTU/DIVU: latch operands, counter=WIDTH, go to BUSY.
- BUSY:
  - in_ready=0.
  - Multiply: one shift-add step per cycle. Divide: one restoring step per cycle.
  - Counter decrements each cycle. On the step where counter reaches 0, HI/LO are written and state goes to DONE.
  - out_valid therefore rises WIDTH+1 cycles after acceptance.
- MULTU result: {hi, lo} = in1*in2 (2*WIDTH-bit product); out = lo.
- DIVU result: lo = quotient, hi = remainder; out = lo.
- DIVU by zero: lo = all ones, hi = in1; no trap; takes the normal WIDTH+1 latency.
- MFHI/MFLO: single-cycle; out = hi or lo as of the accept edge.
- DONE:
  - out_valid=1, in_ready=0.
  - out, zero and overflow are held stable until out_ready=1.
  - At the handshake edge, return to IDLE; out_valid drops the next cycle.
  - No accept in the same cycle as output handshake. Minimum throughput is one op every 2 cycles.
- in_valid while in_ready=0 is ignored; the requester must hold it.
- ctrl and operands are sampled only at the accept edge; later changes have no effect.
- HI/LO change only at MULTU/DIVU completion or reset. Single-cycle ops never modify them.

Test Plan:
1. Reset mid-op (WIDTH=32): accept MULTU, pull rst_n low at cycle 10 → out_valid=0, in_ready=1, MFHI and MFLO both return 0.
2. ADD in1=0x7FFFFFFF, in2=0x00000001 → out=0x80000000, overflow=1, zero=0, out_valid 1 cycle after accept. SUB 5-5 → out=0, zero=1, overflow=0.
3. MULTU 0xFFFFFFFF×0x00000002 → out_valid exactly 33 cycles after accept, out=lo=0xFFFFFFFE. Following MFHI → 0x00000001.
4. DIVU 100/7 → lo=14, hi=2. DIVU 5/0 → lo=0xFFFFFFFF, hi=5, latency 33.
5. Backpressure: out_ready=0 for 5 cycles after out_valid → out stable, in_ready=0, a concurrent in_valid is not accepted. out_ready=1 → IDLE next cycle.
6. Compare/shift: SLT −1 vs 1 → 1. SLTU same operands → 0. SRA 0x80000000 by in2=0x24 (shift 4) → 0xF8000000. SRL same → 0x08000000. Undefined ctrl 1111 → 0.
